// File: rtl/pid_move_seq.sv
// Heading-aligned move sequencer: align, ramp forward speed up, count line crossings, ramp down.
// All outputs are registered, one cycle after their inputs. There is no backpressure, and start is dropped while busy.
module pid_move_seq #(
    parameter bit          FAST_SIM  = 1'b1,
    parameter logic [9:0]  MAX_SPD   = 10'h300,
    parameter logic [11:0] ALIGN_THR = 12'h02C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] des_hdg,
    input  logic [2:0]  num_sq,
    input  logic [11:0] heading,
    input  logic        heading_rdy,
    input  logic        cntrIR,
    output logic        moving,
    output logic        err_vld,
    output logic [11:0] error,
    output logic [9:0]  frwrd,
    output logic        busy,
    output logic        done
);

    localparam logic [9:0]  INC     = FAST_SIM ? 10'h020 : 10'h004;
    localparam logic [10:0] DEC     = {INC, 1'b0};
    localparam logic [12:0] THR_POS = {1'b0, ALIGN_THR};

    typedef enum logic [2:0] {IDLE, ALIGN, RAMP_UP, RAMP_DN, DONE} state_t;

    state_t      state, state_nxt;
    logic [11:0] des_hdg_reg;
    logic [2:0]  num_sq_reg;
    logic [3:0]  line_cnt, line_cnt_nxt;
    logic [9:0]  frwrd_nxt;
    logic [10:0] up_sum;
    logic [9:0]  up_spd, dn_spd;
    logic [12:0] err_ext;
    logic        aligned;
    logic        mov_nxt;
    logic [11:0] des_sel;

    assign up_sum  = {1'b0, frwrd} + {1'b0, INC};
    assign up_spd  = (up_sum > {1'b0, MAX_SPD}) ? MAX_SPD : up_sum[9:0];
    assign dn_spd  = ({1'b0, frwrd} > DEC) ? (frwrd - DEC[9:0]) : 10'h000;
    assign err_ext = {error[11], error};
    assign aligned = ($signed(err_ext) < $signed(THR_POS)) && ($signed(err_ext) > -$signed(THR_POS));
    // The capture cycle must already measure against the new heading.
    assign des_sel = (state == IDLE) ? des_hdg : des_hdg_reg;
    assign mov_nxt = (state_nxt == ALIGN) || (state_nxt == RAMP_UP) || (state_nxt == RAMP_DN);

    always_comb begin
        state_nxt    = state;
        frwrd_nxt    = frwrd;
        line_cnt_nxt = line_cnt;
        case (state)
            IDLE: begin
                frwrd_nxt = 10'h000;
                if (start) begin
                    state_nxt    = ALIGN;
                    line_cnt_nxt = 4'h0;
                end
            end
            ALIGN: begin
                frwrd_nxt = 10'h000;
                if (err_vld && aligned)
                    state_nxt = (num_sq_reg == 3'd0) ? RAMP_DN : RAMP_UP;
            end
            RAMP_UP: begin
                if (cntrIR && (line_cnt != 4'hF))
                    line_cnt_nxt = line_cnt + 4'h1;
                if (heading_rdy)
                    frwrd_nxt = up_spd;
                // Post-increment count lets the crossing and the speed step land together.
                if (line_cnt_nxt == {num_sq_reg, 1'b0})
                    state_nxt = RAMP_DN;
            end
            RAMP_DN: begin
                if (heading_rdy) begin
                    if (frwrd == 10'h000)
                        state_nxt = DONE;
                    else
                        frwrd_nxt = dn_spd;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                frwrd_nxt = 10'h000;
            end
            default: begin
                state_nxt = IDLE;
                frwrd_nxt = 10'h000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            frwrd       <= 10'h000;
            line_cnt    <= 4'h0;
            des_hdg_reg <= 12'h000;
            num_sq_reg  <= 3'd0;
            moving      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_vld     <= 1'b0;
            error       <= 12'h000;
        end else begin
            state    <= state_nxt;
            frwrd    <= frwrd_nxt;
            line_cnt <= line_cnt_nxt;
            if ((state == IDLE) && start) begin
                des_hdg_reg <= des_hdg;
                num_sq_reg  <= num_sq;
            end
            moving  <= mov_nxt;
            busy    <= (state_nxt != IDLE);
            done    <= (state_nxt == DONE);
            err_vld <= heading_rdy && mov_nxt;
            if (heading_rdy && mov_nxt)
                error <= heading - des_sel;
        end
    end

endmodule

// File: tb/tb_pid_move_seq.sv
// Bench for pid_move_seq: directed scenarios plus randomized traffic against a behavioural model.
module tb_pid_move_seq;

    localparam int INC = 32;
    localparam int MAX = 'h300;
    localparam int THR = 'h2C;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] des_hdg;
    logic [2:0]  num_sq;
    logic [11:0] heading;
    logic        heading_rdy;
    logic        cntrIR;
    logic        moving, err_vld, busy, done;
    logic [11:0] error;
    logic [9:0]  frwrd;

    int n_checks = 0;
    int n_errs   = 0;

    pid_move_seq dut (
        .clk(clk), .rst(rst), .start(start), .des_hdg(des_hdg), .num_sq(num_sq),
        .heading(heading), .heading_rdy(heading_rdy), .cntrIR(cntrIR),
        .moving(moving), .err_vld(err_vld), .error(error), .frwrd(frwrd),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: phase 0 idle, 1 align, 2 speed-up, 3 slow-down, 4 finished.
    int m_phase, m_spd, m_lines, m_des, m_nsq, m_err, m_ev;
    int m_e;

    task automatic model_step();
        if (rst) begin
            m_phase = 0; m_spd = 0; m_lines = 0; m_des = 0; m_nsq = 0; m_err = 0; m_ev = 0;
        end else begin
            m_e = (m_err >= 2048) ? m_err - 4096 : m_err;
            case (m_phase)
                0: if (start) begin
                    m_des = int'(des_hdg); m_nsq = int'(num_sq); m_lines = 0; m_phase = 1;
                end
                1: if (m_ev != 0 && m_e > -THR && m_e < THR) m_phase = (m_nsq == 0) ? 3 : 2;
                2: begin
                    if (cntrIR && m_lines < 15) m_lines = m_lines + 1;
                    if (heading_rdy) m_spd = (m_spd + INC > MAX) ? MAX : m_spd + INC;
                    if (m_lines == 2 * m_nsq) m_phase = 3;
                end
                3: if (heading_rdy) begin
                    if (m_spd == 0) m_phase = 4;
                    else m_spd = (m_spd > 2 * INC) ? m_spd - 2 * INC : 0;
                end
                default: m_phase = 0;
            endcase
            if (m_phase >= 1 && m_phase <= 3 && heading_rdy) begin
                m_ev  = 1;
                m_err = (int'(heading) - m_des + 4096) % 4096;
            end else begin
                m_ev = 0;
            end
        end
    endtask

    always @(posedge clk) model_step();

    task automatic tick(input logic s, input logic hr, input logic ir);
        start = s; heading_rdy = hr; cntrIR = ir;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; heading_rdy = 1'b0; cntrIR = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({moving, err_vld, error, frwrd, busy, done} !== 26'h0) begin
            n_errs++;
            $display("FAIL reset_outputs: got %h expected 0", {moving, err_vld, error, frwrd, busy, done});
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            heading = 12'($urandom);
            tick(1'b0, 1'(i % 2), 1'b0);
            n_checks++;
            if ({moving, err_vld, error, frwrd, busy, done} !== 26'h0) begin
                n_errs++;
                $display("FAIL idle_outputs: cycle %0d got %h expected 0", i, {moving, err_vld, error, frwrd, busy, done});
            end
        end
    endtask

    // Leaves the DUT in the speed-up phase with frwrd at one step, num_sq=2.
    task automatic test_align();
        des_hdg = 12'h000; num_sq = 3'd2; heading = 12'h100;
        tick(1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({moving, busy, frwrd} !== {1'b1, 1'b1, 10'h000}) begin
            n_errs++;
            $display("FAIL align_enter: got mv=%b bz=%b fw=%h expected 1 1 000", moving, busy, frwrd);
        end
        tick(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({err_vld, error} !== {1'b1, 12'h100}) begin
            n_errs++;
            $display("FAIL align_error: got vld=%b err=%h expected 1 100", err_vld, error);
        end
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({moving, frwrd, error} !== {1'b1, 10'h000, 12'h100}) begin
            n_errs++;
            $display("FAIL align_hold: got mv=%b fw=%h err=%h expected 1 000 100", moving, frwrd, error);
        end
        heading = 12'h010;
        tick(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (error !== 12'h010) begin
            n_errs++;
            $display("FAIL align_small_err: got %h expected 010", error);
        end
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (frwrd !== 10'h020) begin
            n_errs++;
            $display("FAIL align_to_ramp: got fw=%h expected 020", frwrd);
        end
    endtask

    task automatic test_ramp();
        for (int i = 2; i <= 23; i++) tick(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (frwrd !== 10'h2E0) begin
            n_errs++;
            $display("FAIL ramp_23: got %h expected 2e0", frwrd);
        end
        tick(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (frwrd !== 10'h300) begin
            n_errs++;
            $display("FAIL ramp_24: got %h expected 300", frwrd);
        end
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (frwrd !== 10'h300) begin
            n_errs++;
            $display("FAIL ramp_clamp: got %h expected 300", frwrd);
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 11; i++) tick(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (frwrd !== 10'h040) begin
            n_errs++;
            $display("FAIL rampdn_11: got %h expected 040", frwrd);
        end
        tick(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({frwrd, done, busy} !== {10'h000, 1'b0, 1'b1}) begin
            n_errs++;
            $display("FAIL rampdn_12: got fw=%h dn=%b bz=%b expected 000 0 1", frwrd, done, busy);
        end
        tick(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({done, moving, err_vld} !== 3'b100) begin
            n_errs++;
            $display("FAIL done_pulse: got dn=%b mv=%b ev=%b expected 1 0 0", done, moving, err_vld);
        end
        tick(1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({done, busy} !== 2'b00) begin
            n_errs++;
            $display("FAIL done_clear: got dn=%b bz=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_wrap();
        des_hdg = 12'h7F0; num_sq = 3'd1; heading = 12'h810;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (error !== 12'h020) begin
            n_errs++;
            $display("FAIL wrap_error: got %h expected 020", error);
        end
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (frwrd !== 10'h020) begin
            n_errs++;
            $display("FAIL wrap_aligned: got fw=%h expected 020", frwrd);
        end
    endtask

    // Continues the num_sq=1 move from test_wrap.
    task automatic test_collisions();
        des_hdg = 12'h400; num_sq = 3'd7;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({error, frwrd} !== {12'h020, 10'h040}) begin
            n_errs++;
            $display("FAIL start_ignored: got err=%h fw=%h expected 020 040", error, frwrd);
        end
        tick(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (frwrd !== 10'h060) begin
            n_errs++;
            $display("FAIL coincident_step: got %h expected 060", frwrd);
        end
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (frwrd !== 10'h020) begin
            n_errs++;
            $display("FAIL coincident_count: got %h expected 020", frwrd);
        end
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (done !== 1'b1) begin
            n_errs++;
            $display("FAIL collide_done: got %b expected 1", done);
        end
        tick(1'b0, 1'b0, 1'b0);
        des_hdg = 12'h000; num_sq = 3'd0; heading = 12'h000;
        for (int i = 0; i < 4; i++) begin
            tick(1'(i == 0), 1'(i % 2), 1'(i == 1));
            n_checks++;
            if ({frwrd, done} !== {10'h000, 1'(i == 3)}) begin
                n_errs++;
                $display("FAIL zero_sq: cycle %0d got fw=%h dn=%b expected 000 %0d", i, frwrd, done, i == 3);
            end
        end
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        des_hdg = 12'h000; num_sq = 3'd3; heading = 12'h000;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (frwrd !== 10'h140) begin
            n_errs++;
            $display("FAIL mid_pre: got %h expected 140", frwrd);
        end
        rst = 1'b1;
        tick(1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        n_checks++;
        if ({frwrd, moving, done, busy} !== 13'h0) begin
            n_errs++;
            $display("FAIL mid_reset: got fw=%h mv=%b dn=%b bz=%b expected 0", frwrd, moving, done, busy);
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1);
        n_checks++;
        if ({busy, moving, done, err_vld} !== 4'h0) begin
            n_errs++;
            $display("FAIL no_resume: got %b%b%b%b expected 0000", busy, moving, done, err_vld);
        end
    endtask

    task automatic test_random();
        logic [25:0] exp_v;
        int off;
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            rst         = ($urandom_range(0, 699) == 0);
            start       = ($urandom_range(0, 15) == 0);
            des_hdg     = 12'($urandom);
            num_sq      = 3'($urandom_range(0, 3));
            off         = int'($urandom_range(0, 90)) - 45;
            heading     = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'(m_des + off);
            heading_rdy = 1'($urandom_range(0, 1));
            cntrIR      = ($urandom_range(0, 5) == 0);
            @(posedge clk);
            @(negedge clk);
            exp_v = {1'(m_phase >= 1 && m_phase <= 3), 1'(m_ev), 12'(m_err), 10'(m_spd),
                     1'(m_phase != 0), 1'(m_phase == 4)};
            n_checks++;
            if ({moving, err_vld, error, frwrd, busy, done} !== exp_v) begin
                n_errs++;
                $display("FAIL random_cycle %0d: got %h expected %h", c,
                         {moving, err_vld, error, frwrd, busy, done}, exp_v);
            end
        end
        rst = 1'b0; start = 1'b0; heading_rdy = 1'b0; cntrIR = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; des_hdg = 12'h000; num_sq = 3'd0;
        heading = 12'h000; heading_rdy = 1'b0; cntrIR = 1'b0;
        @(negedge clk);
        test_reset();
        test_align();
        test_ramp();
        test_wrap();
        test_collisions();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/pid_move_seq.md
PID_MOVE_SEQ -- requirements
Module: pid_move_seq

Interface
REQ-001 SHALL have parameter FAST_SIM, default 1, selecting the ramp step: FAST_SIM=1 gives INC=10'h020; FAST_SIM=0 gives INC=10'h004.
REQ-002 SHALL have parameter MAX_SPD, default 10'h300, as the frwrd ceiling.
REQ-003 SHALL have parameter ALIGN_THR, default 12'h02C, as the heading-aligned magnitude threshold.
REQ-004 SHALL have a single clock and a synchronous, active-high reset; all state SHALL update on the rising clk edge only.
REQ-005 SHALL provide port clk, input, 1 bit: system clock.
REQ-006 SHALL provide port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL provide port start, input, 1 bit: single-cycle move request.
REQ-008 SHALL provide port des_hdg, input, 12 bits: desired heading; captured when start is accepted.
REQ-009 SHALL provide port num_sq, input, 3 bits: squares to travel; captured when start is accepted.
REQ-010 SHALL provide port heading, input, 12 bits: signed gyro heading.
REQ-011 SHALL provide port heading_rdy, input, 1 bit: heading-valid strobe.
REQ-012 SHALL provide port cntrIR, input, 1 bit: single-cycle line-crossing pulse.
REQ-013 SHALL provide port moving, output, 1 bit: PID enable.
REQ-014 SHALL provide port err_vld, output, 1 bit: error-valid strobe to PID.
REQ-015 SHALL provide port error, output, 12 bits: signed heading error to PID.
REQ-016 SHALL provide port frwrd, output, 10 bits: unsigned forward speed to PID.
REQ-017 SHALL provide port busy, output, 1 bit: high while not in IDLE.
REQ-018 SHALL provide port done, output, 1 bit: single-cycle completion pulse.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 error SHALL equal heading - des_hdg_reg, computed modulo 2^12 with natural wrap and no saturation; the PID saturates it downstream.
REQ-021 error and err_vld SHALL update one cycle after heading_rdy (err_vld = heading_rdy delayed 1 cycle); error SHALL hold its value between strobes.
REQ-022 err_vld SHALL assert only while moving=1.
REQ-023 The FSM SHALL have states IDLE, ALIGN, RAMP_UP, RAMP_DN and DONE.
REQ-024 In IDLE: moving=0, frwrd=0, busy=0; when start=1, des_hdg and num_sq SHALL be captured, the line counter cleared, and the FSM SHALL go to ALIGN.
REQ-025 In ALIGN: moving=1 and frwrd=0; on the first registered err_vld with |error| < ALIGN_THR, the FSM SHALL go to RAMP_UP, or to RAMP_DN if num_sq=0.
REQ-026 In RAMP_UP, on each heading_rdy, frwrd SHALL increase by INC, clamped at MAX_SPD with no overshoot; the block SHALL count cntrIR pulses, and when count == 2*num_sq the FSM SHALL go to RAMP_DN.
REQ-027 In RAMP_DN, on each heading_rdy, frwrd SHALL decrease by 2*INC, clamped at 0 with no underflow wrap; when frwrd is 0 and heading_rdy=1 the FSM SHALL go to DONE.
REQ-028 In DONE: done=1 for exactly one cycle, moving=0, then the FSM SHALL return to IDLE.
REQ-029 start while busy=1 SHALL be ignored, leaving the captured values unchanged.
REQ-030 cntrIR outside RAMP_UP SHALL be ignored.
REQ-031 cntrIR coincident with heading_rdy SHALL both be applied in the same cycle.
REQ-032 The line counter SHALL be 4 bits and SHALL saturate at 15.
REQ-033 The terminal-count check SHALL use the post-increment count, so a RAMP_UP→RAMP_DN transition and a frwrd increment may occur in the same cycle.
REQ-034 The ALIGN threshold comparison SHALL be signed magnitude: -ALIGN_THR < error < ALIGN_THR.
REQ-035 Worst-case RAMP_UP→RAMP_DN latency SHALL be 1 cycle after the qualifying cntrIR.

Reset
REQ-036 rst=1 on any edge SHALL force IDLE and set moving=0, err_vld=0, error=0, frwrd=0, busy=0, done=0, line count=0 and captured registers=0.
REQ-037 rst asserted mid-move SHALL clear all state on the next edge with no done pulse.
REQ-038 Operation SHALL resume only on a new start after rst deasserts.

Verification
REQ-039 Reset then idle: rst 2 cycles, heading_rdy toggling -> all outputs 0, err_vld never high.
REQ-040 Align: start, des_hdg=12'h000, heading=12'h100 with heading_rdy -> error=12'h100, stays in ALIGN with frwrd=0; heading=12'h010 -> next strobe moves to RAMP_UP.
REQ-041 Ramp, FAST_SIM=1, num_sq=2: frwrd reaches 10'h300 after 24 heading_rdy strobes and holds; 4 cntrIR -> RAMP_DN, frwrd 0 after 12 strobes, done pulse 1 cycle, busy drops.
REQ-042 Wrap: des_hdg=12'h7F0, heading=12'h810 -> error=12'h020 (wrap, aligned).
REQ-043 Collisions: start during RAMP_UP ignored; cntrIR on the same cycle as heading_rdy counted and frwrd stepped; num_sq=0 -> ALIGN, RAMP_DN, DONE with frwrd=0 throughout.
REQ-044 Reset mid-RAMP_UP with frwrd=10'h140 -> next cycle frwrd=0, moving=0, no done.
